// File: rtl/pusch_buf_pkg.sv
// Shared types and helpers for the PUSCH ping-pong buffer.
//   bank_state_t : life cycle of one bank (EMPTY -> FILLING -> FULL -> DRAINING)
//   buf_dbg_t    : snapshot of the control state, brought out for observation
//   addr_width() : bank address width derived from the bank depth
package pusch_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    typedef struct packed {
        bank_state_t bank0;
        bank_state_t bank1;
        logic        wr_sel;
        logic        rd_sel;
    } buf_dbg_t;

    // At least one address bit, even for a one-word bank.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pusch_sdp_ram.sv
// Simple dual-port RAM with a registered read port.
//   clk    : single clock
//   rst_n  : synchronous active-low reset, clears only the output register
//   we     : write enable, writes wdata to waddr
//   re     : read enable, loads rdata from raddr; rdata holds while re is low
//   rdata  : registered read data (1-cycle latency)
module pusch_sdp_ram #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The output register doubles as the consumer-facing data register, so it
    // is reset to give a clean zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pusch_pingpong_buf.sv
// Two-bank ping-pong buffer between a block producer (mapper) and a block
// consumer (FFT/IFFT). The producer fills one bank while the consumer drains
// the other; each bank holds one block of up to DEPTH words.
//   clk, rst_n         : single clock, synchronous active-low reset
//   wr_valid/wr_ready  : producer handshake; wr_data holds NUM_CH samples,
//                        channel 0 in the LSBs; wr_last closes the block
//   rd_valid/rd_ready  : consumer handshake; rd_data/rd_last registered
//   rd_len             : word count of the bank being drained (0 when idle)
//   bank_full          : per bank, 1 while FULL or DRAINING
//   overflow           : sticky, set by a write attempt while wr_ready=0
//   dbg                : bank states and bank selects
//
// Handshake: a word moves on a clk edge where valid && ready are both high.
// A valid source holds its word stable until it moves; ready may change
// freely. wr_ready and rd_valid depend only on registered state.
module pusch_pingpong_buf
    import pusch_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 1200,
    parameter int ADDR_W     = addr_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_last,
    output logic                         wr_ready,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_last,
    output logic [ADDR_W:0]              rd_len,
    output logic [1:0]                   bank_full,
    output logic                         overflow,
    output buf_dbg_t                     dbg
);

    localparam int WORD_W = NUM_CH * DATA_WIDTH;
    localparam int LEN_W  = ADDR_W + 1;
    // Bank bit is concatenated above the word address, so each bank occupies
    // a power-of-two stride of the array.
    localparam int RAM_DEPTH = 2 << ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_WADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  ONE_L      = LEN_W'(1);

    // Registered state
    bank_state_t       state_q [2];
    logic [LEN_W-1:0]  len_q   [2];
    logic              wr_sel_q, rd_sel_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [LEN_W-1:0]  raddr_q;
    logic              rd_valid_q, rd_last_q, overflow_q;

    // Next-state values
    bank_state_t       state_d [2];
    logic [LEN_W-1:0]  len_d   [2];
    logic              wr_sel_d, rd_sel_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [LEN_W-1:0]  raddr_d;
    logic              rd_valid_d, rd_last_d, overflow_d;

    // Decoded events
    logic              wr_ready_c, wr_fire, wr_close;
    logic              rd_release, rd_issue;
    logic              iss_sel;
    logic [LEN_W-1:0]  iss_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;

        // ---- write side ----
        wr_ready_c = (state_q[wr_sel_q] == EMPTY) || (state_q[wr_sel_q] == FILLING);
        wr_fire    = wr_valid && wr_ready_c;
        wr_close   = wr_fire && (wr_last || (waddr_q == LAST_WADDR));
        overflow_d = overflow_q || (wr_valid && !wr_ready_c);

        if (wr_fire) begin
            waddr_d = waddr_q + ONE_A;
            if (state_q[wr_sel_q] == EMPTY) begin
                state_d[wr_sel_q] = FILLING;
            end
        end
        if (wr_close) begin
            state_d[wr_sel_q] = FULL;
            len_d[wr_sel_q]   = LEN_W'(waddr_q) + ONE_L;
            wr_sel_d          = ~wr_sel_q;
            waddr_d           = '0;
        end

        // ---- read side ----
        // When the consumer takes the last word of a bank, the next read is
        // aimed straight at the other bank so blocks stream without a bubble.
        rd_release = rd_valid_q && rd_ready && rd_last_q;
        iss_sel    = rd_release ? ~rd_sel_q : rd_sel_q;
        iss_addr   = rd_release ? '0 : raddr_q;
        rd_issue   = ((state_q[iss_sel] == FULL) || (state_q[iss_sel] == DRAINING))
                     && (iss_addr < len_q[iss_sel])
                     && (!rd_valid_q || rd_ready);

        if (rd_release) begin
            state_d[rd_sel_q] = EMPTY;
            rd_sel_d          = ~rd_sel_q;
            raddr_d           = '0;
        end

        if (rd_issue) begin
            raddr_d    = iss_addr + ONE_L;
            rd_valid_d = 1'b1;
            rd_last_d  = (iss_addr == (len_q[iss_sel] - ONE_L));
            if (state_q[iss_sel] == FULL) begin
                state_d[iss_sel] = DRAINING;
            end
        end else if (rd_ready) begin
            // Current word (if any) leaves and nothing replaces it.
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
    end

    pusch_sdp_ram #(
        .WIDTH (WORD_W),
        .DEPTH (RAM_DEPTH),
        .AW    (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire),
        .waddr ({wr_sel_q, waddr_q}),
        .wdata (wr_data),
        .re    (rd_issue),
        .raddr ({iss_sel, iss_addr[ADDR_W-1:0]}),
        .rdata (rd_data)
    );

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_full[b] = (state_q[b] == FULL) || (state_q[b] == DRAINING);
        end
    end

    assign wr_ready   = wr_ready_c;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign overflow   = overflow_q;
    assign rd_len     = ((state_q[rd_sel_q] == FULL) || (state_q[rd_sel_q] == DRAINING))
                        ? len_q[rd_sel_q] : '0;
    assign dbg.bank0  = state_q[0];
    assign dbg.bank1  = state_q[1];
    assign dbg.wr_sel = wr_sel_q;
    assign dbg.rd_sel = rd_sel_q;

endmodule

// File: tb/tb_pusch_pingpong_buf.sv
// Directed bench for pusch_pingpong_buf with DEPTH=8, NUM_CH=2, DATA_WIDTH=18.
module tb_pusch_pingpong_buf;
    import pusch_buf_pkg::*;

    localparam int DW  = 18;
    localparam int NCH = 2;
    localparam int DEP = 8;
    localparam int AW  = 3;
    localparam int WW  = NCH * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [WW-1:0] wr_data;
    logic          wr_last;
    logic          wr_ready;
    logic          rd_valid;
    logic          rd_ready;
    logic [WW-1:0] rd_data;
    logic          rd_last;
    logic [AW:0]   rd_len;
    logic [1:0]    bank_full;
    logic          overflow;
    buf_dbg_t      dbg;

    int checks   = 0;
    int failures = 0;

    // Expected output words: {rd_last, rd_data}
    logic [WW:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pusch_pingpong_buf #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .DEPTH      (DEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_len    (rd_len),
        .bank_full (bank_full),
        .overflow  (overflow),
        .dbg       (dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // A word moves on the next posedge when valid && ready; sample mid-cycle.
    always @(negedge clk) begin : scoreboard
        logic [WW:0] e;
        if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                check("rd_extra_word", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("rd_word", {rd_last, rd_data}, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [WW-1:0] d, input logic last, input logic exp_last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        exp_q.push_back({exp_last, d});
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((rd_valid || bank_full != 2'b00) && n < 64) begin
            tick();
            n++;
        end
        check(tag, {rd_valid, bank_full}, 3'b000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_len", rd_len, 0);
        check("rst_bank_full", bank_full, 0);
        check("rst_overflow", overflow, 0);

        // Basic fill/drain: words 1..5, last on 5
        rd_ready = 1'b1;
        for (int i = 1; i <= 5; i++) write_word(WW'(i), i == 5, i == 5);
        check("t1_valid_at_close", rd_valid, 0);
        check("t1_rd_len", rd_len, 5);
        check("t1_bank_full", bank_full, 2'b01);
        tick();
        check("t1_first_valid", rd_valid, 1);
        check("t1_first_data", rd_data, 1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("t1_stream_valid", rd_valid, 1);
            check("t1_stream_data", rd_data, i);
        end
        check("t1_rd_last", rd_last, 1);
        tick();
        check("t1_done_valid", rd_valid, 0);
        check("t1_done_full", bank_full, 0);

        // Ping-pong: A = 8 words (forced close), B = 3 words right behind
        for (int i = 0; i < 8; i++) write_word(WW'(256 + i), 1'b0, i == 7);
        check("t2_wr_ready_b", wr_ready, 1);
        for (int i = 0; i < 3; i++) write_word(WW'(512 + i), i == 2, i == 2);
        check("t2_len_a", rd_len, 8);
        for (int n = 11; n <= 18; n++) begin
            tick();
            check("t2_no_gap", rd_valid, 1);
            check("t2_rd_len", rd_len, (n <= 15) ? 8 : 3);
        end
        tick();
        check("t2_done_valid", rd_valid, 0);
        check("t2_done_full", bank_full, 0);

        // Backpressure: rd_ready 1,0,0,1 once the drain starts
        for (int i = 0; i < 4; i++) write_word(WW'(768 + i), i == 3, i == 3);
        tick();
        check("t3_first_data", rd_data, 768);
        tick();
        rd_ready = 1'b0;
        tick();
        check("t3_hold_valid", rd_valid, 1);
        check("t3_hold_data", rd_data, 769);
        check("t3_hold_last", rd_last, 0);
        tick();
        check("t3_hold_data2", rd_data, 769);
        rd_ready = 1'b1;
        wait_idle("t3_drained");

        // Overflow: both banks full with the consumer stalled
        rd_ready = 1'b0;
        write_word(WW'(1024), 1'b0, 1'b0);
        write_word(WW'(1025), 1'b1, 1'b1);
        write_word(WW'(1280), 1'b0, 1'b0);
        write_word(WW'(1281), 1'b1, 1'b1);
        check("t4_wr_ready", wr_ready, 0);
        check("t4_bank_full", bank_full, 2'b11);
        wr_valid = 1'b1;
        wr_data  = WW'(36'hBAD);
        tick();
        check("t4_overflow_set", overflow, 1);
        tick();
        wr_valid = 1'b0;
        tick();
        check("t4_overflow_sticky", overflow, 1);
        check("t4_wr_ready_still", wr_ready, 0);
        check("t4_stall_data", rd_data, 1024);
        rd_ready = 1'b1;
        wait_idle("t4_drained");
        check("t4_overflow_after", overflow, 1);

        // Single-word block
        write_word(WW'(42), 1'b1, 1'b1);
        check("t5_rd_len", rd_len, 1);
        tick();
        check("t5_valid", rd_valid, 1);
        check("t5_data", rd_data, 42);
        check("t5_last", rd_last, 1);
        tick();
        check("t5_done", rd_valid, 0);

        // Reset during a drain
        for (int i = 0; i < 4; i++) write_word(WW'(1536 + i), i == 3, i == 3);
        tick();
        check("t6_draining", rd_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check("t6_rd_valid", rd_valid, 0);
        check("t6_bank_full", bank_full, 0);
        check("t6_wr_ready", wr_ready, 1);
        check("t6_overflow", overflow, 0);
        check("t6_rd_len", rd_len, 0);
        check("t6_rd_data", rd_data, 0);
        write_word(WW'(1792), 1'b0, 1'b0);
        write_word(WW'(1793), 1'b1, 1'b1);
        wait_idle("t6_drained");

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
